param_seq_divider: RTL and testbench

- Parametrised, multi-cycle restoring divider; next generation of the team's fixed 32/16 sequential divider.
- Adds configurable widths and an optional signed mode with truncating (C-style) semantics.
- Adds a start/busy/done handshake, plus divide-by-zero and signed-overflow flags.
- Sits beside the ALU as the long-latency divide unit; the ALU sequencer issues one operation and waits for done.

---
 rtl/param_seq_divider_if.sv | 34 +++
 rtl/param_seq_divider.sv | 182 ++++++++++++++++++
 tb/tb_param_seq_divider.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_seq_divider_if.sv
//==============================================================================
// Module  : param_seq_divider_if
// Brief   : Request/response bundle between the ALU sequencer and the divider.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface param_seq_divider_if #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
);
    logic                  start;
    logic                  is_signed;
    logic [DIVIDEND_W-1:0] inDividend;
    logic [DIVISOR_W-1:0]  inDivisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] Quotient;
    logic [DIVISOR_W-1:0]  Remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output start, is_signed, inDividend, inDivisor,
        input  busy, done, Quotient, Remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, is_signed, inDividend, inDivisor,
        output busy, done, Quotient, Remainder, div_by_zero, overflow
    );
endinterface

`default_nettype wire

// File: rtl/param_seq_divider.sv
//==============================================================================
// Module  : param_seq_divider
// Brief   : Multi-cycle restoring divider, one quotient bit per clock, with
//           optional truncating signed mode and zero/overflow flags.
// Revision: 1.0
//==============================================================================
`default_nettype none

module param_seq_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16,
    parameter int SIGNED_EN  = 1
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    param_seq_divider_if.slave    bus
);

    localparam int                 c_CNT_W     = $clog2(DIVIDEND_W) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;

    logic [DIVIDEND_W-1:0] r_work;
    logic [DIVISOR_W-1:0]  r_dvs_mag;
    logic [DIVISOR_W:0]    r_prem;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_dbz_pend;
    logic                  r_ovf_pend;

    logic                  r_done;
    logic                  r_div_by_zero;
    logic                  r_overflow;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;

    logic                  w_signed;
    logic                  w_dvd_neg;
    logic                  w_dvs_neg;
    logic                  w_dvs_zero;
    logic                  w_ovf;
    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dvs_mag;
    logic [DIVISOR_W+1:0]  w_shift;
    logic [DIVISOR_W+1:0]  w_diff;
    logic                  w_fits;
    logic [DIVIDEND_W-1:0] w_quot_fix;
    logic [DIVISOR_W-1:0]  w_rem_mag;
    logic [DIVISOR_W-1:0]  w_rem_fix;

    generate
        if (SIGNED_EN != 0) begin : g_signed
            assign w_signed = bus.is_signed;
        end else begin : g_unsigned
            assign w_signed = 1'b0;
        end
    endgenerate

    // Operand conditioning at the accepting edge
    assign w_dvd_neg  = w_signed & bus.inDividend[DIVIDEND_W-1];
    assign w_dvs_neg  = w_signed & bus.inDivisor[DIVISOR_W-1];
    assign w_dvd_mag  = w_dvd_neg ? -bus.inDividend : bus.inDividend;
    assign w_dvs_mag  = w_dvs_neg ? -bus.inDivisor  : bus.inDivisor;
    assign w_dvs_zero = ~|bus.inDivisor;
    assign w_ovf      = w_signed & (bus.inDividend == {1'b1, {(DIVIDEND_W-1){1'b0}}})
                                 & (&bus.inDivisor);

    // Restoring step: the extra top bit of the difference is its sign
    assign w_shift = {r_prem, r_work[DIVIDEND_W-1]};
    assign w_diff  = w_shift - {2'b00, r_dvs_mag};
    assign w_fits  = ~w_diff[DIVISOR_W+1];

    assign w_rem_mag  = r_prem[DIVISOR_W-1:0];
    assign w_quot_fix = r_neg_q ? -r_work    : r_work;
    assign w_rem_fix  = r_neg_r ? -w_rem_mag : w_rem_mag;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = w_dvs_zero ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == c_LAST_ITER) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_work        <= '0;
            r_dvs_mag     <= '0;
            r_prem        <= '0;
            r_count       <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dbz_pend    <= 1'b0;
            r_ovf_pend    <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
            r_quot        <= '0;
            r_rem         <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_count       <= '0;
                r_prem        <= '0;
                r_dvs_mag     <= w_dvs_mag;
                r_dbz_pend    <= w_dvs_zero;
                r_ovf_pend    <= w_ovf;
                r_div_by_zero <= 1'b0;
                r_overflow    <= 1'b0;
                // A zero divisor keeps the raw dividend so FIX can return it unmodified
                if (w_dvs_zero) begin
                    r_work  <= bus.inDividend;
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else begin
                    r_work  <= w_dvd_mag;
                    r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                    r_neg_r <= w_dvd_neg;
                end
            end else if (r_state == S_RUN) begin
                r_count <= r_count + c_CNT_W'(1);
                r_prem  <= w_fits ? w_diff[DIVISOR_W:0] : w_shift[DIVISOR_W:0];
                r_work  <= {r_work[DIVIDEND_W-2:0], w_fits};
            end else if (r_state == S_FIX) begin
                r_done        <= 1'b1;
                r_div_by_zero <= r_dbz_pend;
                r_overflow    <= r_ovf_pend;
                if (r_dbz_pend) begin
                    r_quot <= '1;
                    r_rem  <= r_work[DIVISOR_W-1:0];
                end else begin
                    r_quot <= w_quot_fix;
                    r_rem  <= w_rem_fix;
                end
            end
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.Quotient    = r_quot;
    assign bus.Remainder   = r_rem;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_param_seq_divider.sv
//==============================================================================
// Module  : tb_param_seq_divider
// Brief   : Directed and random checks of param_seq_divider against an
//           arithmetic reference model; default and small unsigned builds.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_param_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    param_seq_divider_if #(.DIVIDEND_W(32), .DIVISOR_W(16)) bus ();
    param_seq_divider_if #(.DIVIDEND_W(8),  .DIVISOR_W(4))  bus_s ();

    param_seq_divider #(.DIVIDEND_W(32), .DIVISOR_W(16), .SIGNED_EN(1)) u_dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    param_seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4), .SIGNED_EN(0)) u_small (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: C-style truncating division on plain integers
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  input int nw, input int dw, input bit sgn,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output bit dbz, output bit ovf);
        longint ua, ub, sa, sb, qq, rr, mn, md;
        mn  = (longint'(1) << nw) - 1;
        md  = (longint'(1) << dw) - 1;
        ua  = longint'(a) & mn;
        ub  = longint'(b) & md;
        ovf = 1'b0;
        dbz = (ub == 0);
        if (dbz) begin
            qq = mn;
            rr = ua & md;
        end else if (sgn) begin
            sa  = (ua >= (longint'(1) << (nw - 1))) ? ua - (longint'(1) << nw) : ua;
            sb  = (ub >= (longint'(1) << (dw - 1))) ? ub - (longint'(1) << dw) : ub;
            qq  = sa / sb;
            rr  = sa % sb;
            ovf = (sa == -(longint'(1) << (nw - 1))) && (sb == -1);
        end else begin
            qq = ua / ub;
            rr = ua % ub;
        end
        q = 32'(qq & mn);
        r = 16'(rr & md);
    endfunction

    function automatic logic rd_done(input bit s);
        return s ? bus_s.done : bus.done;
    endfunction

    function automatic logic rd_busy(input bit s);
        return s ? bus_s.busy : bus.busy;
    endfunction

    task automatic scramble();
        bus.inDividend   = $urandom;
        bus.inDivisor    = 16'($urandom);
        bus.is_signed    = 1'($urandom);
        bus_s.inDividend = 8'($urandom);
        bus_s.inDivisor  = 4'($urandom);
        bus_s.is_signed  = 1'($urandom);
    endtask

    task automatic run_op(input bit s, input logic [31:0] a, input logic [15:0] b,
                          input bit sg, input string tag);
        logic [31:0] eq;
        logic [15:0] er;
        bit          edz, eov;
        int          n, nw, lat;
        nw = s ? 8 : 32;
        model(a, b, nw, s ? 4 : 16, sg && !s, eq, er, edz, eov);
        lat = edz ? 1 : nw + 1;
        @(negedge clk);
        if (s) begin
            bus_s.start = 1'b1; bus_s.is_signed = sg;
            bus_s.inDividend = a[7:0]; bus_s.inDivisor = b[3:0];
        end else begin
            bus.start = 1'b1; bus.is_signed = sg;
            bus.inDividend = a; bus.inDivisor = b;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus_s.start = 1'b0;
        scramble();
        chk({tag, " busy"}, 64'(rd_busy(s)), 64'd1);
        n = 0;
        while (!rd_done(s) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " quot"}, s ? 64'(bus_s.Quotient) : 64'(bus.Quotient), 64'(eq));
        chk({tag, " rem"}, s ? 64'(bus_s.Remainder) : 64'(bus.Remainder), 64'(er));
        chk({tag, " dbz"}, s ? 64'(bus_s.div_by_zero) : 64'(bus.div_by_zero), 64'(edz));
        chk({tag, " ovf"}, s ? 64'(bus_s.overflow) : 64'(bus.overflow), 64'(eov));
        chk({tag, " busy@done"}, 64'(rd_busy(s)), 64'd0);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, 64'(rd_done(s)), 64'd0);
    endtask

    initial begin
        int n, m, seen;
        logic [31:0] a;
        logic [15:0] b;

        bus.start = 1'b0; bus.is_signed = 1'b0; bus.inDividend = '0; bus.inDivisor = '0;
        bus_s.start = 1'b0; bus_s.is_signed = 1'b0; bus_s.inDividend = '0; bus_s.inDivisor = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst quot", 64'(bus.Quotient), 64'd0);
        chk("rst rem", 64'(bus.Remainder), 64'd0);
        chk("rst flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
        rst_n = 1'b1;

        run_op(1'b0, 32'd100, 16'd7, 1'b0, "u100/7");
        run_op(1'b0, -32'sd100, 16'd7, 1'b1, "s-100/7");
        run_op(1'b0, 32'd100, -16'sd7, 1'b1, "s100/-7");
        run_op(1'b0, 32'hFFFF_FFFF, 16'hFFFF, 1'b0, "uFFFF");
        run_op(1'b0, 32'h1234_5678, 16'h0000, 1'b1, "dbz");
        run_op(1'b0, 32'h8000_0000, 16'hFFFF, 1'b1, "s ovf");
        run_op(1'b0, 32'h8000_0000, 16'hFFFF, 1'b0, "u min/FFFF");
        run_op(1'b0, 32'h8000_0000, 16'h8000, 1'b1, "s min/min");
        run_op(1'b1, 32'd100, 16'd7, 1'b1, "small 100/7");
        run_op(1'b1, 32'd255, 16'd0, 1'b0, "small dbz");

        // start pulsed while RUN must not disturb or queue
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.inDividend = 32'd100; bus.inDivisor = 16'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.inDividend = 32'd555; bus.inDivisor = 16'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 11;
        while (!bus.done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrun latency", 64'(n), 64'd33);
        chk("midrun quot", 64'(bus.Quotient), 64'd14);
        chk("midrun rem", 64'(bus.Remainder), 64'd2);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        chk("midrun no queue", 64'(seen), 64'd0);

        // start held across done: second op accepted in the done cycle
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.inDividend = 32'd1000; bus.inDivisor = 16'd10;
        @(posedge clk); #1;
        bus.inDividend = 32'd77; bus.inDivisor = 16'd5;
        n = 0;
        while (!bus.done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held first latency", 64'(n), 64'd33);
        chk("held first quot", 64'(bus.Quotient), 64'd100);
        chk("held first rem", 64'(bus.Remainder), 64'd0);
        m = 0;
        while (!(m > 0 && bus.done) && m < 200) begin
            @(posedge clk); #1;
            m++;
            if (m == 1) begin
                chk("held second busy", 64'(bus.busy), 64'd1);
                bus.start = 1'b0;
            end
        end
        chk("held second spacing", 64'(m), 64'd34);
        chk("held second quot", 64'(bus.Quotient), 64'd15);
        chk("held second rem", 64'(bus.Remainder), 64'd2);

        // reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.inDividend = 32'd100; bus.inDivisor = 16'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst done", 64'(bus.done), 64'd0);
        chk("midrst quot", 64'(bus.Quotient), 64'd0);
        chk("midrst rem", 64'(bus.Remainder), 64'd0);
        chk("midrst flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
        chk("midrst small quot", 64'(bus_s.Quotient), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        chk("midrst no done", 64'(seen), 64'd0);
        run_op(1'b0, 32'hDEAD_BEEF, 16'h0123, 1'b0, "post-reset");

        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = 16'($urandom);
            if (k % 5 == 1) b = 16'($urandom_range(1, 15));
            if (k % 7 == 0) b = 16'd0;
            if (k % 11 == 3) begin a = 32'h8000_0000; b = 16'hFFFF; end
            run_op(1'b0, a, b, 1'($urandom), "rand");
        end
        for (int k = 0; k < 20; k++) begin
            run_op(1'b1, $urandom, 16'($urandom), 1'($urandom), "rand small");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
